// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and line-level constants for serial_tx
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// rtl/flex_pts_sr.sv - parallel-to-serial shift register, fills with ones as it shifts
module flex_pts_sr #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr;

  // Load has priority over shift; vacated positions fill with the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '1;
    end else if (load_enable) begin
      sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) begin
        sr <= {sr[NUM_BITS-2:0], 1'b1};
      end else begin
        sr <= {1'b1, sr[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed serial transmitter; even parity bit enabled by SERIAL_TX_PARITY_EN
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int SHIFT_MSB    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_out,
  output logic                tx_busy,
  output logic                frame_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  // The line lags the state by one register stage, so STOP leaves one clock
  // early and the first IDLE clock supplies the final stop-bit clock. This
  // lets a held tx_valid start the next frame with no gap on the line.
  localparam logic [TW-1:0] STOP_END = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BITS - 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [IW-1:0] bit_idx;
  logic [IW-1:0] idx_next;
  logic          accept;
  logic          shift;
  logic          stop_end;
  logic          line_level;
  logic          sr_out;
  logic          done_pend;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_ready & tx_valid;

  flex_pts_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (accept),
    .shift_enable (shift),
    .parallel_in  (tx_data),
    .serial_out   (sr_out)
  );

  // Next-state, bit timer, bit index and the line level for the current state.
  always_comb begin
    state_next = state;
    timer_next = timer;
    idx_next   = bit_idx;
    shift      = 1'b0;
    stop_end   = 1'b0;
    line_level = IDLE_LEVEL;
    case (state)
      IDLE: begin
        timer_next = '0;
        idx_next   = '0;
        if (tx_valid) state_next = START;
      end
      START: begin
        line_level = START_BIT;
        if (timer == BIT_END) begin
          timer_next = '0;
          state_next = DATA;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DATA: begin
        line_level = sr_out;
        if (timer == BIT_END) begin
          timer_next = '0;
          shift      = 1'b1;
          if (bit_idx == LAST_IDX) begin
            idx_next   = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = bit_idx + 1'b1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        line_level = parity_bit;
        if (timer == BIT_END) begin
          timer_next = '0;
          state_next = STOP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
`endif
      STOP: begin
        line_level = STOP_BIT;
        if (timer == STOP_END) begin
          timer_next = '0;
          stop_end   = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        timer_next = '0;
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State, bit timer and bit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= idx_next;
    end
  end

  // Registered line and end-of-frame pulse, delayed to line up with the last stop clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out     <= IDLE_LEVEL;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_out     <= line_level;
      done_pend  <= stop_end;
      frame_done <= done_pend;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the word captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter: accepts one NUM_BITS word over a valid/ready handshake and drives it onto a single idle-high serial line. Frame order: start bit (0), data bits, optional even-parity bit, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It is the transmit counterpart of the team's serial receive path: a flex shift register plus bit timer, driving the same line format the receiver samples.

## Interface
- NUM_BITS, 8, data bits per frame; legal range ≥ 2.
- CLKS_PER_BIT, 10, clocks per bit period; legal range ≥ 2.
- SHIFT_MSB, 0: 0 sends LSB first, 1 sends MSB first.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  NUM_BITS  word to send; sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  high exactly when the state is IDLE.
- tx_out  output  1  serial line, registered, idles high.
- tx_busy  output  1  high in every non-IDLE state.
- frame_done  output  1  one-cycle pulse at the end of the stop bit.

## Operation
- Reset values on any clock edge with rst=1: state IDLE, tx_out=1, tx_ready=1, tx_busy=0, frame_done=0, counters 0, shift register all ones.
- Accept: rising edge with tx_ready=1 and tx_valid=1. tx_data is loaded into the shift register and the state goes to START. Later changes on tx_data have no effect.
- States and transitions:
  - IDLE: tx_out=1. On accept, go to START.
  - START: tx_out=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: tx_out is the current shift-register output bit. After each CLKS_PER_BIT clocks, shift once and increment the bit index. After NUM_BITS bits, go to PARITY if compiled in, else STOP.
  - PARITY: tx_out is the XOR of the latched word for CLKS_PER_BIT clocks, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT clocks, then go to IDLE with a frame_done pulse.
- The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The bit index is ceil(log2(NUM_BITS+1)) bits wide.
- tx_valid is ignored while busy. There is no queuing.
- A rst during a frame aborts it on that edge: tx_out=1 on the next cycle and no frame_done pulse.

## Timing
- Accept at edge k: tx_out=0 from edge k+1 (registered output).
- Frame length F = (NUM_BITS + 2 + P) × CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- frame_done is high for the cycle after edge k+F. tx_ready is also high in that cycle.
- Back-to-back: if tx_valid is held high, the next accept happens at edge k+F. The next start bit follows the stop bit directly, with no extra idle cycle.
- rst has priority over accept when both occur on the same edge.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state exists, P=1, and even parity is sent (total ones in data+parity is even).
- SERIAL_TX_PARITY_EN undefined: PARITY is not compiled, P=0, and DATA goes directly to STOP.

## Structure
- Package serial_tx_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, START, DATA, PARITY, STOP};
  - the line-level constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- Sub-module flex_pts_sr, a parallel-to-serial shift register with parameters NUM_BITS and SHIFT_MSB and ports clk, rst, load_enable, shift_enable, parallel_in, serial_out.
  - On load_enable, it loads parallel_in.
  - On shift_enable, it shifts and fills with 1.
  - serial_out is bit 0 (SHIFT_MSB=0) or bit NUM_BITS-1 (SHIFT_MSB=1).
- The top level holds the FSM, the bit timer, the bit index, the parity register and the output register.

## Test plan
- Reset: hold rst for 3 cycles while tx_valid=1 → no accept; tx_out=1, tx_ready=1, tx_busy=0 throughout and one cycle after release.
- Single frame, defaults, parity off, tx_data=8'hA5 → tx_out is 0 for 10 clocks, then 1,0,1,0,0,1,0,1 at 10 clocks each, then 1 for 10 clocks. frame_done pulses 100 cycles after accept.
- Parity on, tx_data=8'h07 → parity bit 1; tx_data=8'hA5 → parity bit 0. frame_done at 110 cycles after accept.
- SHIFT_MSB=1, tx_data=8'hA5 → data bits 1,0,1,0,0,1,0,1 in MSB-first order. With tx_data=8'h01 the only 1 is the last data bit.
- Back-to-back with tx_valid held high for 8'h55 then 8'hAA → the second start bit begins the cycle after the first stop bit ends. No idle gap; frame_done pulses twice.
- Assert rst for 1 cycle in the middle of the DATA state → tx_out=1 the next cycle, no frame_done, tx_ready=1. A new 8'h3C frame then completes correctly.
